memoria_arbitro: RTL and testbench

- Two-requester controller/arbiter sharing the single `memoria` RAM.
  - Port A: instruction fetch.
  - Port B: datapath load/store.
- Serialises accesses, drives all RAM address/data/write-enable inputs, tracks the RAM's one-cycle registered read, and returns read data with a per-port valid pulse.
- Sits between the CPU control unit and `memoria`.
- `clock` also feeds the RAM's `write_clock` and `read_clock`.

---
 rtl/memoria_arbitro_pkg.sv | 8 +
 rtl/memoria_arbitro_rr.sv | 15 +
 rtl/memoria_arbitro.sv | 92 +++++++++
 tb/tb_memoria_arbitro.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/memoria_arbitro_pkg.sv
// memoria_arbitro_pkg: shared states, port ids and default widths for the memoria arbiter.
package memoria_arbitro_pkg;
  typedef enum logic [1:0] {IDLE, ACESSO, ESPERA} estado_t;
  localparam logic PORTA_A = 1'b0;
  localparam logic PORTA_B = 1'b1;
  localparam int DATA_WIDTH_PAD = 8;
  localparam int ADDR_WIDTH_PAD = 4;
endpackage

// File: rtl/memoria_arbitro_rr.sv
// rr_arbitro_2: 2-way round-robin picker; the pointer names the port favoured on a tie.
module rr_arbitro_2
  import memoria_arbitro_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_upd,
  output logic [1:0] o_gnt,
  output logic       o_ptr_nxt
);
  always_comb begin
    o_gnt = &i_req ? (i_ptr == PORTA_B ? 2'b10 : 2'b01) : i_req;
    o_ptr_nxt = (i_upd && &i_req) ? ~i_ptr : i_ptr;
  end
endmodule

// File: rtl/memoria_arbitro.sv
// memoria_arbitro: serialises two requesters onto the memoria RAM (registered read, falling-edge write).
// MEMORIA_ARB_PRIO_FIXA_EN selects fixed priority (A wins ties) instead of round-robin.
module memoria_arbitro
  import memoria_arbitro_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_PAD,
  parameter int ADDR_WIDTH = ADDR_WIDTH_PAD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic                  mem_EscMen,
  input  logic [DATA_WIDTH-1:0] mem_saida
);
  estado_t r_state, w_state_nxt;
  logic r_port, r_we, r_rvalid_a, r_rvalid_b;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [1:0] w_gnt;
  logic w_amostra;
  assign w_amostra = r_state == IDLE;
`ifdef MEMORIA_ARB_PRIO_FIXA_EN
  assign w_gnt = {req_b & ~req_a, req_a};
`else
  logic r_ptr, w_ptr_nxt;
  rr_arbitro_2 u_rr (
    .i_req    ({req_b, req_a}),
    .i_ptr    (r_ptr),
    .i_upd    (w_amostra),
    .o_gnt    (w_gnt),
    .o_ptr_nxt(w_ptr_nxt)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) r_ptr <= PORTA_A;
    else r_ptr <= w_ptr_nxt;
`endif
  always_comb begin
    w_state_nxt = r_state;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    mem_EscMen = 1'b0;
    w_state_nxt = r_state == IDLE ? (|w_gnt ? ACESSO : IDLE) :
                  r_state == ACESSO ? (r_we ? IDLE : ESPERA) : IDLE;
    gnt_a = r_state == ACESSO && r_port == PORTA_A;
    gnt_b = r_state == ACESSO && r_port == PORTA_B;
    mem_EscMen = r_state == ACESSO && r_we;
  end
  // request fields are captured at the sample edge so the requester may move on after gnt
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_port <= PORTA_A;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rvalid_a <= r_state == ESPERA && r_port == PORTA_A;
      r_rvalid_b <= r_state == ESPERA && r_port == PORTA_B;
      if (r_state == ESPERA) r_rdata <= mem_saida;
      if (w_amostra && |w_gnt) begin
        r_port <= w_gnt[1];
        r_we <= w_gnt[1] ? we_b : we_a;
        r_addr <= w_gnt[1] ? addr_b : addr_a;
        r_wdata <= w_gnt[1] ? wdata_b : wdata_a;
      end
    end
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rdata = r_rdata;
  assign mem_data = r_wdata;
  assign mem_write_addr = r_addr;
  assign mem_read_addr = r_addr;
endmodule

// File: tb/tb_memoria_arbitro.sv
// tb_memoria_arbitro: directed vectors plus corner sequences against a behavioural memoria model.
module tb_memoria_arbitro;
  logic clock, reset;
  logic req_a, we_a, req_b, we_b;
  logic [3:0] addr_a, addr_b, mem_write_addr, mem_read_addr;
  logic [7:0] wdata_a, wdata_b, rdata, mem_data, mem_saida;
  logic gnt_a, gnt_b, rvalid_a, rvalid_b, mem_EscMen;
  logic [7:0] ram [16];
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic       p;
    logic       we;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t tab[8];

  memoria_arbitro #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .gnt_a(gnt_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .gnt_b(gnt_b), .rvalid_b(rvalid_b),
    .rdata(rdata), .mem_data(mem_data), .mem_write_addr(mem_write_addr), .mem_read_addr(mem_read_addr),
    .mem_EscMen(mem_EscMen), .mem_saida(mem_saida)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (mem_EscMen) ram[mem_write_addr] <= mem_data;
  always @(posedge clock) mem_saida <= ram[mem_read_addr];

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  always @(negedge clock) if (!reset) chk("rvalid_exclusive", 32'(rvalid_a & rvalid_b), 32'd0);

  function automatic logic [31:0] saidas();
    return 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_EscMen, rdata, mem_data, mem_write_addr, mem_read_addr});
  endfunction

  task automatic acesso(input logic p, input logic we, input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp);
    int n;
    if (p) begin req_b = 1; we_b = we; addr_b = a; wdata_b = d; end
    else begin req_a = 1; we_a = we; addr_a = a; wdata_a = d; end
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!(p ? gnt_b : gnt_a) && n < 20);
    chk("lat_gnt", 32'(n), 32'd1);
    chk("gnt_other", 32'(p ? gnt_a : gnt_b), 32'd0);
    req_a = 0; req_b = 0;
    chk("EscMen_c1", 32'(mem_EscMen), 32'(we));
    chk(we ? "write_addr" : "read_addr", 32'(we ? mem_write_addr : mem_read_addr), 32'(a));
    if (we) begin
      chk("mem_data", 32'(mem_data), 32'(d));
      @(posedge clock); #1;
      chk("EscMen_c2", 32'(mem_EscMen), 32'd0);
    end else begin
      @(posedge clock); #1;
      chk("rvalid_c2", 32'({rvalid_a, rvalid_b}), 32'd0);
      @(posedge clock); #1;
      chk("rvalid_c3", 32'({rvalid_a, rvalid_b}), p ? 32'd1 : 32'd2);
      chk("rdata", 32'(rdata), 32'(exp));
    end
  endtask

  task automatic pulso_reset();
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, g, e;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[1] = 8'h10;
    ram[2] = 8'h20;
    tab[0] = '{1'b0, 1'b1, 4'd3, 8'hA5, 8'h00};
    tab[1] = '{1'b0, 1'b0, 4'd3, 8'h00, 8'hA5};
    tab[2] = '{1'b1, 1'b1, 4'd5, 8'h3C, 8'h00};
    tab[3] = '{1'b1, 1'b0, 4'd5, 8'h00, 8'h3C};
    tab[4] = '{1'b0, 1'b0, 4'd5, 8'h00, 8'h3C};
    tab[5] = '{1'b1, 1'b0, 4'd3, 8'h00, 8'hA5};
    tab[6] = '{1'b0, 1'b0, 4'd1, 8'h00, 8'h10};
    tab[7] = '{1'b1, 1'b0, 4'd2, 8'h00, 8'h20};
    reset = 1;
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", saidas(), 32'd0);
    reset = 0;

    // reset during the write cycle must abort it before the falling edge
    req_a = 1; we_a = 1; addr_a = 4'd9; wdata_a = 8'h11;
    @(posedge clock); #1;
    chk("abort_gnt", 32'(gnt_a), 32'd1);
    chk("abort_EscMen", 32'(mem_EscMen), 32'd1);
    reset = 1;
    #1;
    chk("abort_outputs", saidas(), 32'd0);
    req_a = 0;
    @(posedge clock); #1;
    chk("abort_outputs_held", saidas(), 32'd0);
    reset = 0;
    acesso(1'b0, 1'b0, 4'd9, 8'h00, 8'h00);

    foreach (tab[i]) acesso(tab[i].p, tab[i].we, tab[i].a, tab[i].d, tab[i].exp);

    // simultaneous reads right after reset
    pulso_reset();
    req_a = 1; we_a = 0; addr_a = 4'd1;
    req_b = 1; we_b = 0; addr_b = 4'd2;
    @(posedge clock); #1;
    chk("sim_gnt_c1", 32'({gnt_a, gnt_b}), 32'd2);
    req_a = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("sim_rvalid_a", 32'({rvalid_a, rvalid_b, gnt_b}), 32'd4);
    chk("sim_rdata_a", 32'(rdata), 32'h10);
    @(posedge clock); #1;
    chk("sim_gnt_b", 32'({gnt_a, gnt_b}), 32'd1);
    req_b = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("sim_rvalid_b", 32'({rvalid_a, rvalid_b}), 32'd1);
    chk("sim_rdata_b", 32'(rdata), 32'h20);

    // fairness with both requesters held for 8 grants
    pulso_reset();
    req_a = 1; we_a = 0; addr_a = 4'd1;
    req_b = 1; we_b = 0; addr_b = 4'd2;
    g = 0; n = 0;
    while (g < 8 && n < 60) begin
      @(posedge clock); #1;
      n++;
      if (rvalid_a) chk("fair_rdata_a", 32'(rdata), 32'h10);
      if (rvalid_b) chk("fair_rdata_b", 32'(rdata), 32'h20);
      if (gnt_a || gnt_b) begin
`ifdef MEMORIA_ARB_PRIO_FIXA_EN
        e = 0;
`else
        e = g % 2;
`endif
        chk("fair_order", 32'(gnt_b), 32'(e));
        g++;
      end
    end
    chk("fair_count", 32'(g), 32'd8);
    req_a = 0; req_b = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;

    // B writes addr 15 while A queues a read of the same address
    req_b = 1; we_b = 1; addr_b = 4'd15; wdata_b = 8'h7E;
    @(posedge clock); #1;
    chk("ord_gnt_b", 32'({gnt_a, gnt_b}), 32'd1);
    req_b = 0;
    req_a = 1; we_a = 0; addr_a = 4'd15;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!gnt_a && n < 20);
    chk("ord_lat_gnt_a", 32'(n), 32'd2);
    req_a = 0;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!rvalid_a && n < 20);
    chk("ord_lat_rvalid", 32'(n), 32'd2);
    chk("ord_rdata", 32'(rdata), 32'h7E);

    // back-to-back writes across the address wrap
    req_a = 1; we_a = 1; addr_a = 4'd15; wdata_a = 8'h5A;
    @(posedge clock); #1;
    chk("wrap_w1", 32'({gnt_a, mem_EscMen, mem_write_addr, mem_data}), 32'h3F5A);
    addr_a = 4'd0; wdata_a = 8'hC3;
    @(posedge clock); #1;
    chk("wrap_gap", 32'({gnt_a, mem_EscMen}), 32'd0);
    @(posedge clock); #1;
    chk("wrap_w2", 32'({gnt_a, mem_EscMen, mem_write_addr, mem_data}), 32'h30C3);
    req_a = 0;
    @(posedge clock); #1;
    chk("wrap_EscMen_off", 32'(mem_EscMen), 32'd0);
    acesso(1'b0, 1'b0, 4'd15, 8'h00, 8'h5A);
    acesso(1'b1, 1'b0, 4'd0, 8'h00, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
